rangefinder_sample_capture: RTL and testbench
=============================================

// Module: rangefinder_sample_capture
// PURPOSE
//  Upstream feeder for the dual-port sample RAM: after a CPU start pulse and a holdoff delay,
//  captures NUM_SAMPLES ADC samples and writes them to RAM port 2 at addresses 0..NUM_SAMPLES-1.
//  Then flags done and pulses irq so the Nios reads the buffer via port 1.
// PARAMETERS
//  ADDR_WIDTH    8    RAM port-2 address width
//  DATA_WIDTH    8    ADC sample / RAM data width
//  NUM_SAMPLES   256  samples per capture; 1 <= NUM_SAMPLES <= 2**ADDR_WIDTH
//  HOLDOFF_WIDTH 16   width of holdoff delay input
//  DECIM_FACTOR  4    keep 1 of every DECIM_FACTOR valid samples (RANGEFINDER_DECIM_EN only); >= 1
// PORTS
//  clk             in  1             system clock, the same as the RAM port-2 clock
//  reset           in  1             synchronous, active-high
//  start           in  1             one-cycle capture request
//  abort           in  1             cancel capture
//  holdoff         in  HOLDOFF_WIDTH cycles from start to capture; sampled when start is accepted
//  adc_data        in  DATA_WIDTH    ADC sample
//  adc_valid       in  1             adc_data valid this cycle
//  ram_address     out ADDR_WIDTH    RAM address2
//  ram_writedata   out DATA_WIDTH    RAM writedata2
//  ram_chipselect  out 1             RAM chipselect2
//  ram_write       out 1             RAM write2
//  ram_clken       out 1             RAM clken2, constant 1 after reset
//  busy            out 1             1 in HOLDOFF or CAPTURE
//  done            out 1             sticky; last capture completed
//  irq             out 1             one-cycle pulse on completion
//  start_err       out 1             sticky; start received while busy
//  samples_written out ADDR_WIDTH+1  samples written in current/last capture
// BEHAVIOUR
//  Reset: state=IDLE; every output is 0 except ram_clken=1. Reset mid-capture returns to these values next cycle.
//  States: IDLE, HOLDOFF, CAPTURE.
//  IDLE + start (no abort):
//   - clear done, start_err and samples_written
//   - load holdoff counter; ptr=0
//   - go to HOLDOFF, or to CAPTURE if holdoff==0
//  HOLDOFF:
//   - counter decrements every cycle; adc_valid is ignored
//   - holdoff=N gives N cycles in HOLDOFF, then CAPTURE
//  CAPTURE, accepted adc_valid at cycle t: at t+1 (registered outputs)
//   - ram_chipselect=ram_write=1 for exactly one cycle
//   - ram_address=ptr, ram_writedata=adc_data sampled at t
//   - ptr and samples_written then increment
//   - writes are back-to-back capable (one per cycle); gaps in adc_valid produce no write
//  Completion: the cycle the NUM_SAMPLES-th write is issued, the state goes to IDLE.
//   done=1 and irq=1 in that same cycle; irq drops next cycle.
//  Address range: ptr never exceeds NUM_SAMPLES-1; no wrap, no writes after the last sample.
//  Idle outputs: ram_chipselect=ram_write=0 whenever no write is issued; address/data hold their last value.
//  start while busy: ignored; start_err=1 (sticky until next accepted start).
//  abort in HOLDOFF/CAPTURE: go to IDLE next cycle.
//   - abort wins over a same-cycle adc_valid (that sample is not written)
//   - no done, no irq; samples_written holds its value
//  abort in IDLE: no effect. start+abort in the same IDLE cycle: abort wins, start is dropped.
//  Completion and abort in the same cycle: abort wins; no done, no irq.
// CONFIGURATION
//  RANGEFINDER_DECIM_EN defined:
//   - a decimation counter (reset on entry to CAPTURE) counts adc_valid in CAPTURE
//   - the 1st, (1+DECIM_FACTOR)th, ... valid samples are accepted; others are discarded
//   - DECIM_FACTOR=1 behaves as undefined
//  RANGEFINDER_DECIM_EN undefined: every adc_valid in CAPTURE is accepted; DECIM_FACTOR is unused.
// TESTING
//  T1 reset: assert reset 2 cycles mid-capture -> next cycle all outputs 0, ram_clken=1, state IDLE.
//  T2 NUM_SAMPLES=4, holdoff=3, start, adc_valid=1 continuously, adc_data ramp 0x10,0x11,...
//     -> no write for 3 cycles; then writes addr 0..3 with data 0x10..0x13 on 4 consecutive cycles
//     -> irq is one cycle wide; done=1, samples_written=4.
//  T3 start again during T2 HOLDOFF -> start_err=1; capture result is identical to T2.
//  T4 NUM_SAMPLES=8, abort after the 2nd write -> IDLE, no irq, done=0, samples_written=2, no further writes.
//  T5 DECIM_EN, DECIM_FACTOR=4, NUM_SAMPLES=4, holdoff=0, 16 valids with data 0x00..0x0F
//     -> data 0x00,0x04,0x08,0x0C written to addr 0..3.
//  T6 adc_valid every 3rd cycle, holdoff=0, NUM_SAMPLES=3 -> one write per valid, addr 0,1,2; irq after the 3rd.

Source files
------------

// File: rtl/rangefinder_sample_capture.sv
// rangefinder_sample_capture
//  Feeds RAM port 2 with a burst of ADC samples. A CPU start pulse arms a
//  holdoff delay, after which NUM_SAMPLES valid samples are written to
//  addresses 0..NUM_SAMPLES-1. Completion raises sticky done and a one-cycle irq.
//  Optional feature: define RANGEFINDER_DECIM_EN to keep only 1 of every
//  DECIM_FACTOR valid samples during capture.
module rangefinder_sample_capture #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_SAMPLES   = 256,
    parameter int HOLDOFF_WIDTH = 16,
    parameter int DECIM_FACTOR  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff,
    input  logic [DATA_WIDTH-1:0]    adc_data,
    input  logic                     adc_valid,
    output logic [ADDR_WIDTH-1:0]    ram_address,
    output logic [DATA_WIDTH-1:0]    ram_writedata,
    output logic                     ram_chipselect,
    output logic                     ram_write,
    output logic                     ram_clken,
    output logic                     busy,
    output logic                     done,
    output logic                     irq,
    output logic                     start_err,
    output logic [ADDR_WIDTH:0]      samples_written
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    // Count value at which the write being issued is the final one.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [HOLDOFF_WIDTH-1:0] holdoff_cnt_q, holdoff_cnt_d;
    logic [ADDR_WIDTH-1:0]    ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]    ram_address_q, ram_address_d;
    logic [DATA_WIDTH-1:0]    ram_writedata_q, ram_writedata_d;
    logic                     ram_write_q, ram_write_d;
    logic                     ram_clken_q, ram_clken_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     irq_q, irq_d;
    logic                     start_err_q, start_err_d;
    logic [CNT_W-1:0]         samples_written_q, samples_written_d;
    logic                     sample_take_s;

`ifdef RANGEFINDER_DECIM_EN
    localparam int DECIM_W = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
    localparam logic [DECIM_W-1:0] DECIM_LAST = DECIM_W'(DECIM_FACTOR - 1);

    logic [DECIM_W-1:0] decim_cnt_q, decim_cnt_d;

    // Decimation phase: zero outside CAPTURE, advances on each valid sample in CAPTURE.
    always_comb begin
        decim_cnt_d = decim_cnt_q;
        if (state_q != ST_CAPTURE) begin
            decim_cnt_d = '0;
        end else if (adc_valid && !abort) begin
            if (decim_cnt_q == DECIM_LAST) begin
                decim_cnt_d = '0;
            end else begin
                decim_cnt_d = decim_cnt_q + DECIM_W'(1);
            end
        end else begin
            decim_cnt_d = decim_cnt_q;
        end
    end

    // Decimation phase register.
    always_ff @(posedge clk) begin
        if (reset) begin
            decim_cnt_q <= '0;
        end else begin
            decim_cnt_q <= decim_cnt_d;
        end
    end

    // Only the first sample of each group of DECIM_FACTOR is kept.
    assign sample_take_s = adc_valid && (decim_cnt_q == '0);
`else
    assign sample_take_s = adc_valid;
`endif

    // Next-state and next-output logic for the capture sequencer.
    always_comb begin
        state_d           = state_q;
        holdoff_cnt_d     = holdoff_cnt_q;
        ptr_d             = ptr_q;
        ram_address_d     = ram_address_q;
        ram_writedata_d   = ram_writedata_q;
        ram_write_d       = 1'b0;
        ram_clken_d       = 1'b1;
        done_d            = done_q;
        irq_d             = 1'b0;
        start_err_d       = start_err_q;
        samples_written_d = samples_written_q;

        case (state_q)
            ST_IDLE: begin
                // abort alongside start drops the request
                if (start && !abort) begin
                    done_d            = 1'b0;
                    start_err_d       = 1'b0;
                    samples_written_d = '0;
                    ptr_d             = '0;
                    holdoff_cnt_d     = holdoff;
                    if (holdoff == '0) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d = ST_HOLDOFF;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                start_err_d = start_err_q | start;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (holdoff_cnt_q <= HOLDOFF_WIDTH'(1)) begin
                    holdoff_cnt_d = '0;
                    state_d       = ST_CAPTURE;
                end else begin
                    holdoff_cnt_d = holdoff_cnt_q - HOLDOFF_WIDTH'(1);
                end
            end
            ST_CAPTURE: begin
                start_err_d = start_err_q | start;
                // abort beats both a pending sample and completion
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sample_take_s) begin
                    ram_write_d       = 1'b1;
                    ram_address_d     = ptr_q;
                    ram_writedata_d   = adc_data;
                    samples_written_d = samples_written_q + CNT_W'(1);
                    if (samples_written_q == LAST_CNT) begin
                        // ptr stays at the last address; no wrap
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        irq_d   = 1'b1;
                    end else begin
                        ptr_d = ptr_q + ADDR_WIDTH'(1);
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            holdoff_cnt_q     <= '0;
            ptr_q             <= '0;
            ram_address_q     <= '0;
            ram_writedata_q   <= '0;
            ram_write_q       <= 1'b0;
            ram_clken_q       <= 1'b1;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            irq_q             <= 1'b0;
            start_err_q       <= 1'b0;
            samples_written_q <= '0;
        end else begin
            state_q           <= state_d;
            holdoff_cnt_q     <= holdoff_cnt_d;
            ptr_q             <= ptr_d;
            ram_address_q     <= ram_address_d;
            ram_writedata_q   <= ram_writedata_d;
            ram_write_q       <= ram_write_d;
            ram_clken_q       <= ram_clken_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            irq_q             <= irq_d;
            start_err_q       <= start_err_d;
            samples_written_q <= samples_written_d;
        end
    end

    assign ram_address     = ram_address_q;
    assign ram_writedata   = ram_writedata_q;
    assign ram_chipselect  = ram_write_q;
    assign ram_write       = ram_write_q;
    assign ram_clken       = ram_clken_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign irq             = irq_q;
    assign start_err       = start_err_q;
    assign samples_written = samples_written_q;

endmodule

// File: tb/tb_rangefinder_sample_capture.sv
// Directed bench for rangefinder_sample_capture. Main instance uses
// ADDR_WIDTH=2 / NUM_SAMPLES=4 so the last address is also the top of the
// address space. The decimation instance exists only when RANGEFINDER_DECIM_EN is defined.
module tb_rangefinder_sample_capture;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int NS = 4;
    localparam int HW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [HW-1:0] holdoff;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_writedata;
    logic          ram_chipselect;
    logic          ram_write;
    logic          ram_clken;
    logic          busy;
    logic          done;
    logic          irq;
    logic          start_err;
    logic [AW:0]   samples_written;

    int n_tests = 0;
    int n_fail  = 0;

    // Clock generator.
    always #5 clk = ~clk;

    rangefinder_sample_capture #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SAMPLES(NS),
        .HOLDOFF_WIDTH(HW), .DECIM_FACTOR(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .holdoff(holdoff), .adc_data(adc_data), .adc_valid(adc_valid),
        .ram_address(ram_address), .ram_writedata(ram_writedata),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_clken(ram_clken), .busy(busy), .done(done), .irq(irq),
        .start_err(start_err), .samples_written(samples_written)
    );

    // Flattened view of every output: addr, data, cs, wr, clken, busy, done, irq, err, count.
    wire [19:0] obs_all = {ram_address, ram_writedata, ram_chipselect, ram_write,
                           ram_clken, busy, done, irq, start_err, samples_written};
    localparam logic [19:0] RESET_VEC = {2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,
                                         1'b0, 1'b0, 1'b0, 3'b000};

`ifdef RANGEFINDER_DECIM_EN
    logic [AW-1:0] d_address;
    logic [DW-1:0] d_writedata;
    logic          d_chipselect, d_write, d_clken, d_busy, d_done, d_irq, d_start_err;
    logic [AW:0]   d_samples_written;

    rangefinder_sample_capture #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SAMPLES(NS),
        .HOLDOFF_WIDTH(HW), .DECIM_FACTOR(4)
    ) dut_dec (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .holdoff(holdoff), .adc_data(adc_data), .adc_valid(adc_valid),
        .ram_address(d_address), .ram_writedata(d_writedata),
        .ram_chipselect(d_chipselect), .ram_write(d_write),
        .ram_clken(d_clken), .busy(d_busy), .done(d_done), .irq(d_irq),
        .start_err(d_start_err), .samples_written(d_samples_written)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; holdoff = 16'd0;
        adc_data = 8'h00; adc_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        n_tests++;
        if (obs_all !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_initial: got %h expected %h", obs_all, RESET_VEC);
        end
        // get a capture going, then reset in the middle of it
        start = 1'b1; holdoff = 16'd0;
        tick();
        start = 1'b0; adc_valid = 1'b1; adc_data = 8'h5A;
        tick();
        n_tests++;
        if ({ram_write, busy, ram_address, ram_writedata} !== {1'b1, 1'b1, 2'd0, 8'h5A}) begin
            n_fail++; $display("FAIL reset_precapture: got %h expected %h",
                               {ram_write, busy, ram_address, ram_writedata}, {1'b1, 1'b1, 2'd0, 8'h5A});
        end
        adc_data = 8'h5B;
        tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if (obs_all !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_midcapture: got %h expected %h", obs_all, RESET_VEC);
        end
        tick();
        reset = 1'b0;
        tick();
        n_tests++;
        if (obs_all !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_stays_idle: got %h expected %h", obs_all, RESET_VEC);
        end
        adc_valid = 1'b0;
    endtask

    // Full capture with holdoff=3 and a ramp; optionally restart during HOLDOFF.
    task automatic run_capture(input bit restart);
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        holdoff = 16'd3; start = 1'b1; adc_valid = 1'b1; adc_data = 8'hEE;
        tick();
        start = restart;
        holdoff = 16'd9;  // must not affect the capture already accepted
        n_tests++;
        if ({busy, ram_write, done, start_err, samples_written} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            n_fail++; $display("FAIL cap_accept(r=%0d): got %b expected %b", restart,
                               {busy, ram_write, done, start_err, samples_written}, 7'b1000000);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0;
            n_tests++;
            if ({ram_write, ram_chipselect, busy} !== 3'b001) begin
                n_fail++; $display("FAIL cap_holdoff%0d(r=%0d): got %b expected 001", i, restart,
                                   {ram_write, ram_chipselect, busy});
            end
        end
        adc_data = 8'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_addr = AW'(i);
            exp_data = 8'h10 + DW'(i);
            n_tests++;
            if ({ram_chipselect, ram_write, ram_address, ram_writedata} !== {1'b1, 1'b1, exp_addr, exp_data}) begin
                n_fail++; $display("FAIL cap_write%0d(r=%0d): got %h expected %h", i, restart,
                                   {ram_chipselect, ram_write, ram_address, ram_writedata},
                                   {1'b1, 1'b1, exp_addr, exp_data});
            end
            n_tests++;
            if ({irq, done, busy} !== ((i == 3) ? 3'b110 : 3'b001)) begin
                n_fail++; $display("FAIL cap_flags%0d(r=%0d): got %b expected %b", i, restart,
                                   {irq, done, busy}, (i == 3) ? 3'b110 : 3'b001);
            end
            adc_data = 8'h11 + DW'(i);
        end
        tick();
        n_tests++;
        if ({irq, done, ram_write, ram_chipselect, busy, samples_written} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4}) begin
            n_fail++; $display("FAIL cap_after(r=%0d): got %b expected %b", restart,
                               {irq, done, ram_write, ram_chipselect, busy, samples_written}, 8'b01000100);
        end
        n_tests++;
        if ({start_err, ram_address, ram_writedata} !== {restart, 2'd3, 8'h13}) begin
            n_fail++; $display("FAIL cap_hold(r=%0d): got %h expected %h", restart,
                               {start_err, ram_address, ram_writedata}, {restart, 2'd3, 8'h13});
        end
        adc_valid = 1'b0;
        tick();
    endtask

    task automatic test_capture();
        run_capture(1'b0);
    endtask

    task automatic test_start_busy();
        run_capture(1'b1);
    endtask

    task automatic test_abort();
        holdoff = 16'd0; start = 1'b1; adc_valid = 1'b0;
        tick();
        start = 1'b0;
        n_tests++;
        if ({busy, done, start_err} !== 3'b100) begin
            n_fail++; $display("FAIL abort_accept: got %b expected 100", {busy, done, start_err});
        end
        adc_valid = 1'b1; adc_data = 8'hA0;
        tick();
        adc_data = 8'hA1;
        tick();
        n_tests++;
        if ({ram_write, ram_address, ram_writedata} !== {1'b1, 2'd1, 8'hA1}) begin
            n_fail++; $display("FAIL abort_write2: got %h expected %h",
                               {ram_write, ram_address, ram_writedata}, {1'b1, 2'd1, 8'hA1});
        end
        abort = 1'b1; adc_data = 8'hA2;
        tick();
        abort = 1'b0;
        n_tests++;
        if ({ram_write, busy, irq, done, samples_written} !== {1'b0, 1'b0, 1'b0, 1'b0, 3'd2}) begin
            n_fail++; $display("FAIL abort_state: got %b expected 00000010",
                               {ram_write, busy, irq, done, samples_written});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({ram_write, irq, ram_address, ram_writedata, samples_written} !== {1'b0, 1'b0, 2'd1, 8'hA1, 3'd2}) begin
                n_fail++; $display("FAIL abort_quiet%0d: got %h expected %h", i,
                                   {ram_write, irq, ram_address, ram_writedata, samples_written},
                                   {1'b0, 1'b0, 2'd1, 8'hA1, 3'd2});
            end
        end
        adc_valid = 1'b0;
        // start together with abort in IDLE is dropped; lone abort does nothing
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b0;
        n_tests++;
        if ({busy, done, start_err, samples_written} !== {1'b0, 1'b0, 1'b0, 3'd2}) begin
            n_fail++; $display("FAIL abort_idle: got %b expected 000010",
                               {busy, done, start_err, samples_written});
        end
    endtask

    // Abort arriving with the final sample wins over completion.
    task automatic test_abort_last();
        holdoff = 16'd0; start = 1'b1;
        tick();
        start = 1'b0; adc_valid = 1'b1; adc_data = 8'hC0;
        tick(); tick(); tick();
        n_tests++;
        if ({ram_write, ram_address, samples_written, busy} !== {1'b1, 2'd2, 3'd3, 1'b1}) begin
            n_fail++; $display("FAIL abortlast_pre: got %b expected 1103 1",
                               {ram_write, ram_address, samples_written, busy});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0; adc_valid = 1'b0;
        n_tests++;
        if ({ram_write, irq, done, busy, samples_written} !== {1'b0, 1'b0, 1'b0, 1'b0, 3'd3}) begin
            n_fail++; $display("FAIL abortlast_post: got %b expected 0000011",
                               {ram_write, irq, done, busy, samples_written});
        end
        tick();
    endtask

    // One valid every third cycle: one write per valid, no writes in gaps.
    task automatic test_sparse();
        logic [DW-1:0] exp_data;
        holdoff = 16'd0; start = 1'b1; adc_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            adc_valid = 1'b1; adc_data = 8'h50 + DW'(k);
            exp_data = 8'h50 + DW'(k);
            tick();
            adc_valid = 1'b0;
            n_tests++;
            if ({ram_write, ram_address, ram_writedata, irq} !== {1'b1, AW'(k), exp_data, (k == 3)}) begin
                n_fail++; $display("FAIL sparse_write%0d: got %h expected %h", k,
                                   {ram_write, ram_address, ram_writedata, irq},
                                   {1'b1, AW'(k), exp_data, (k == 3)});
            end
            for (int g = 0; g < 2; g++) begin
                tick();
                n_tests++;
                if ({ram_write, irq} !== 2'b00) begin
                    n_fail++; $display("FAIL sparse_gap%0d_%0d: got %b expected 00", k, g, {ram_write, irq});
                end
            end
        end
        n_tests++;
        if ({done, busy, samples_written} !== {1'b1, 1'b0, 3'd4}) begin
            n_fail++; $display("FAIL sparse_end: got %b expected 10100", {done, busy, samples_written});
        end
    endtask

`ifdef RANGEFINDER_DECIM_EN
    task automatic test_decim();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        holdoff = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            adc_valid = 1'b1; adc_data = DW'(i);
            tick();
            n_tests++;
            if ((i % 4) == 0) begin
                if ({d_write, d_address, d_writedata, d_irq} !== {1'b1, AW'(i / 4), DW'(i), (i == 12)}) begin
                    n_fail++; $display("FAIL decim_write%0d: got %h expected %h", i,
                                       {d_write, d_address, d_writedata, d_irq},
                                       {1'b1, AW'(i / 4), DW'(i), (i == 12)});
                end
            end else begin
                if ({d_write, d_irq} !== 2'b00) begin
                    n_fail++; $display("FAIL decim_skip%0d: got %b expected 00", i, {d_write, d_irq});
                end
            end
        end
        adc_valid = 1'b0;
    endtask
`endif

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

    // Test sequence.
    initial begin
        test_reset();
        test_capture();
        test_start_busy();
        test_abort();
        test_abort_last();
        test_sparse();
`ifdef RANGEFINDER_DECIM_EN
        test_decim();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
